// File: rtl/tap_delay_bank_pkg.sv
// rtl/tap_delay_bank_pkg.sv - shared mode codes, ramp state encoding and helpers for tap_delay_bank
package tap_delay_bank_pkg;

  localparam int MODE_FIXED    = 0;
  localparam int MODE_VARIABLE = 1;
  localparam int MODE_VAR_LOAD = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } ramp_state_t;

  function automatic int div_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tap_delay_chan.sv
// rtl/tap_delay_chan.sv - one channel: delay line, tap counter, pipe register, ramp FSM
// Optional macro: TAP_DELAY_SMOOTH_EN (ld ramps tap one step per STEP_DIV cycles)
module tap_delay_chan
  import tap_delay_bank_pkg::*;
#(
  parameter int DW       = 1,
  parameter int TAP_W    = 5,
  parameter int MODE     = 2,
  parameter int INIT_TAP = 0,
  parameter int PIPE_SEL = 0,
  parameter int STEP_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    din,
  output logic [DW-1:0]    dout,
  input  logic             ce,
  input  logic             inc,
  input  logic             ld,
  input  logic             ldpipe_en,
  input  logic [TAP_W-1:0] cnt_in,
  output logic [TAP_W-1:0] cnt_out,
  output logic             busy
);

  localparam int DEPTH = 2 ** TAP_W;
  localparam logic [TAP_W-1:0] INIT = TAP_W'(INIT_TAP);
  localparam bit CTRL_EN = (MODE != MODE_FIXED);

  logic [DW-1:0]    sr   [DEPTH-1];
  logic [DW-1:0]    taps [DEPTH];
  logic [TAP_W-1:0] tap, tap_n, pipe, pipe_n, load_val, stepped;

  // taps[0] is din itself so tap 0 still gives one register of latency
  always_comb begin
    taps[0] = din;
    for (int i = 1; i < DEPTH; i++) taps[i] = sr[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH - 1; i++) sr[i] <= '0;
      dout <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH - 1; i++) sr[i] <= sr[i-1];
      dout <= taps[tap];
    end
  end

  assign load_val = (MODE == MODE_VAR_LOAD) ? ((PIPE_SEL != 0) ? pipe : cnt_in) : INIT;
  assign stepped  = inc ? tap + TAP_W'(1) : tap - TAP_W'(1);
  assign pipe_n   = (CTRL_EN && ldpipe_en) ? cnt_in : pipe;
  assign cnt_out  = tap;

`ifdef TAP_DELAY_SMOOTH_EN
  localparam int DIV_W = div_width(STEP_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  ramp_state_t      state, state_n;
  logic [TAP_W-1:0] tgt, tgt_n, tgt_req, toward;
  logic [DIV_W-1:0] div, div_n;

  assign tgt_req = ld ? load_val : tgt;
  assign toward  = (tgt_req > tap) ? tap + TAP_W'(1) : tap - TAP_W'(1);
  assign busy    = (state == ST_RAMP);

  always_comb begin
    state_n = state;
    tap_n   = tap;
    tgt_n   = tgt;
    div_n   = div;
    if (CTRL_EN) begin
      case (state)
        ST_IDLE: begin
          if (ld) begin
            tgt_n = load_val;
            div_n = '0;
            if (load_val != tap) state_n = ST_RAMP;
          end else if (ce) begin
            tap_n = stepped;
            tgt_n = stepped;
          end
        end
        ST_RAMP: begin
          // retarget keeps the divider phase; ce is ignored while ramping
          tgt_n = tgt_req;
          if (tgt_req == tap) begin
            state_n = ST_IDLE;
            div_n   = '0;
          end else if (div == DIV_LAST) begin
            div_n = '0;
            tap_n = toward;
            if (toward == tgt_req) state_n = ST_IDLE;
          end else begin
            div_n = div + DIV_W'(1);
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      tgt   <= INIT;
      div   <= '0;
    end else begin
      state <= state_n;
      tgt   <= tgt_n;
      div   <= div_n;
    end
  end
`else
  assign busy = 1'b0;

  always_comb begin
    tap_n = tap;
    if (CTRL_EN) begin
      if (ld)      tap_n = load_val;
      else if (ce) tap_n = stepped;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap  <= INIT;
      pipe <= '0;
    end else begin
      tap  <= tap_n;
      pipe <= pipe_n;
    end
  end

endmodule

// File: rtl/tap_delay_bank.sv
// rtl/tap_delay_bank.sv - NCH-channel programmable clock-cycle tap delay bank
// Optional macro: TAP_DELAY_SMOOTH_EN (forwarded to every tap_delay_chan)
module tap_delay_bank
  import tap_delay_bank_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int DW       = 1,
  parameter int TAP_W    = 5,
  parameter int MODE     = MODE_VAR_LOAD,
  parameter int INIT_TAP = 0,
  parameter int PIPE_SEL = 0,
  parameter int STEP_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*DW-1:0]    din,
  output logic [NCH*DW-1:0]    dout,
  input  logic [NCH-1:0]       ce,
  input  logic [NCH-1:0]       inc,
  input  logic [NCH-1:0]       ld,
  input  logic [NCH-1:0]       ldpipe_en,
  input  logic [NCH*TAP_W-1:0] cnt_in,
  output logic [NCH*TAP_W-1:0] cnt_out,
  output logic [NCH-1:0]       busy
);

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    tap_delay_chan #(
      .DW       (DW),
      .TAP_W    (TAP_W),
      .MODE     (MODE),
      .INIT_TAP (INIT_TAP),
      .PIPE_SEL (PIPE_SEL),
      .STEP_DIV (STEP_DIV)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .din       (din[k*DW +: DW]),
      .dout      (dout[k*DW +: DW]),
      .ce        (ce[k]),
      .inc       (inc[k]),
      .ld        (ld[k]),
      .ldpipe_en (ldpipe_en[k]),
      .cnt_in    (cnt_in[k*TAP_W +: TAP_W]),
      .cnt_out   (cnt_out[k*TAP_W +: TAP_W]),
      .busy      (busy[k])
    );
  end

endmodule
